fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction buffer between fetch and decode.
- Decouples the fetch stage from decode stalls: holds up to DEPTH {pc, instr} pairs in FIFO order.
- Discards all contents on a control-flow redirect (PCSrcM).
- Replaces the single fetch-to-decode register with a ready/valid queue, and adds occupancy and flush-statistics outputs for the trace/perf logic.

Parameters:
- WORD, 32, width of pc and instruction fields.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL, DEPTH-1, occupancy at or above which almost_full is asserted; 1..DEPTH.
- CNT_W, 16, width of the saturating flush statistics counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- push_valid  in  1  fetch presents an entry.
- push_ready  out  1  queue can accept an entry this cycle.
- push_pc  in  WORD  pc of the pushed instruction.
- push_instr  in  WORD  pushed instruction word.
- pop_valid  out  1  head entry is valid for decode.
- pop_ready  in  1  decode consumes the head (driven as !stallD).
- pop_pc  out  WORD  pc of the head entry.
- pop_instr  out  WORD  instruction of the head entry.
- flush  in  1  redirect (PCSrcM); discard all entries.
- count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
- almost_full  out  1  count >= AFULL.
- flushed_cnt  out  CNT_W  saturating total of entries discarded by flush.

Behaviour:
- Storage and pointers:
  - Circular buffer, DEPTH entries.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Separate occupancy register count.
- Reset (reset == 0, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, flushed_cnt = 0.
  - Hence pop_valid = 0, push_ready = 1, almost_full = 0 (when AFULL >= 1).
  - Entry storage is not reset; pop_pc/pop_instr are don't-care while pop_valid = 0.
- Combinational outputs:
  - push_ready = (count != DEPTH).
  - pop_valid = (count != 0).
  - pop_pc/pop_instr = entry[rd_ptr].
  - almost_full = (count >= AFULL).
- Push fires when push_valid & push_ready & !flush: write entry[wr_ptr], wr_ptr += 1.
- Pop fires when pop_valid & pop_ready & !flush: rd_ptr += 1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- Latency: an entry pushed in cycle N is visible at pop in cycle N+1. There is no same-cycle bypass when empty.
- Full (count == DEPTH):
  - push_ready = 0, even if pop_ready = 1 in the same cycle; no pass-through.
  - An entry freed by a pop accepts a push the next cycle.
- Empty: a pop with pop_ready = 1 is ignored; rd_ptr is unchanged.
- Flush has priority over everything in its cycle:
  - The push and pop in that cycle are both suppressed.
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - flushed_cnt += count (value before the flush), saturating at 2^CNT_W - 1.
  - A flush while empty is legal and changes only the pointers.
- Consecutive flush cycles each clear the queue; the pointers stay at 0.
- Reset asserted mid-operation clears state immediately, regardless of flush, push or pop.
- No data corruption on pointer wrap: FIFO order is preserved across the DEPTH-1 -> 0 boundary.

Decomposition:
- Shared package (consts package): WORD, plus the fetch-entry struct typedef {pc, instr} reused by fetch, fetch_queue and decode.
- One natural sub-module: fq_ptr, a wrapping pointer register with increment enable and synchronous clear.
  - Instantiated twice (read and write).
- Storage and count logic stay in fetch_queue.

Test Plan:
- Reset, then push pc=0x0/instr=0x00000013 with pop_ready=0 -> next cycle pop_valid=1, pop_pc=0x0, count=1; preceding reset cycle shows push_ready=1, pop_valid=0.
- DEPTH=4 fill: push pc 0x0,0x4,0x8,0xC with pop_ready=0 -> count=4, push_ready=0, almost_full=1 (asserted at count=3); a 5th push_valid is not accepted.
- Wrap ordering: push 10 entries pc=0x0..0x24 step 4 while popping every other cycle -> pop_pc sequence strictly 0x0,0x4,...,0x24 with no loss or duplication.
- Flush with count=3 and push_valid=1 in the same cycle -> next cycle count=0, pop_valid=0, flushed_cnt=3; the pushed entry is absent.
- Simultaneous push/pop at count=2 -> count stays 2, head advances by one; the at-full variant shows push blocked while the pop succeeds, giving count=3.
- Saturation: CNT_W=2, flush at count=3 twice -> flushed_cnt=3 after both flushes, with no wrap; async reset asserted mid-burst -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: datapath width and the {pc, instr} entry
// exchanged between fetch, the fetch queue and decode.
package fetch_queue_pkg;

  localparam int WORD = 32;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } fetchEntry_t;

  // Occupancy field width for a queue of the given depth (0..depth inclusive).
  function automatic int countBits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear;
// clear wins over increment.
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state is written with <= only, so every reader sees the
  // pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Ready/valid instruction buffer between fetch and decode, emptied on a
// control-flow redirect, with occupancy and flush statistics for perf/trace.
module fetch_queue #(
  parameter int WORD  = fetch_queue_pkg::WORD,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1,
  parameter int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_BITS = fetch_queue_pkg::countBits(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [WORD-1:0]     push_pc,
  input  logic [WORD-1:0]     push_instr,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [WORD-1:0]     pop_pc,
  output logic [WORD-1:0]     pop_instr,
  input  logic                flush,
  output logic [CNT_BITS-1:0] count,
  output logic                almost_full,
  output logic [CNT_W-1:0]    flushed_cnt
);

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } entry_t;

  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] AFULL_C = CNT_BITS'(AFULL);

  // Sum is wide enough for both operands plus a carry so saturation is exact
  // even when the statistics counter is narrower than the occupancy field.
  localparam int SUM_W = ((CNT_W > CNT_BITS) ? CNT_W : CNT_BITS) + 1;
  localparam logic [SUM_W-1:0] STAT_MAX = SUM_W'({CNT_W{1'b1}});

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic               pushFire;
  logic               popFire;
  logic [SUM_W-1:0]   flushSum;
  logic [CNT_W-1:0]   flushedNext;

  assign push_ready  = (count != DEPTH_C);
  assign pop_valid   = (count != '0);
  assign almost_full = (count >= AFULL_C);
  assign pop_pc      = mem[rdPtr].pc;
  assign pop_instr   = mem[rdPtr].instr;

  // A redirect squashes both handshakes in its cycle.
  assign pushFire = push_valid && push_ready && !flush;
  assign popFire  = pop_valid && pop_ready && !flush;

  fq_ptr #(.W(PTR_W)) u_rdPtr (
    .clk   (clk),
    .rst_n (reset),
    .clear (flush),
    .inc   (popFire),
    .ptr   (rdPtr)
  );

  fq_ptr #(.W(PTR_W)) u_wrPtr (
    .clk   (clk),
    .rst_n (reset),
    .clear (flush),
    .inc   (pushFire),
    .ptr   (wrPtr)
  );

  // NOTE: entry storage has no reset; its contents are only observed through
  // pop_valid, which is governed by the reset occupancy count.
  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem[wrPtr] <= '{pc: push_pc, instr: push_instr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (pushFire && !popFire) begin
      count <= count + CNT_BITS'(1);
    end else if (popFire && !pushFire) begin
      count <= count - CNT_BITS'(1);
    end
  end

  always_comb begin
    flushSum    = SUM_W'(flushed_cnt) + SUM_W'(count);
    flushedNext = (flushSum > STAT_MAX) ? {CNT_W{1'b1}} : flushSum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flushed_cnt <= '0;
    end else if (flush) begin
      flushed_cnt <= flushedNext;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues the expected pop stream,
// a negedge monitor compares every consumed head entry against it.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        almost_full;
  logic [1:0]  flushed_cnt;

  int total = 0;
  int bad = 0;
  int mCount = 0;
  fetchEntry_t expQ[$];

  always #5 clk = ~clk;

  fetch_queue #(.WORD(32), .DEPTH(4), .AFULL(3), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_pc     (push_pc),
    .push_instr  (push_instr),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_pc      (pop_pc),
    .pop_instr   (pop_instr),
    .flush       (flush),
    .count       (count),
    .almost_full (almost_full),
    .flushed_cnt (flushed_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a head consumed by decode must be the oldest accepted push.
  always @(negedge clk) begin
    if (reset && pop_valid && pop_ready && !flush) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got pc %0h expected no entry", pop_pc);
      end else begin
        fetchEntry_t e;
        e = expQ.pop_front();
        check("pop_pc", 64'(pop_pc), 64'(e.pc));
        check("pop_instr", 64'(pop_instr), 64'(e.instr));
      end
    end
  end

  // Called at posedge+1; drives one cycle and returns whether the push is accepted.
  task automatic cycle(input bit pv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit pr, input bit fl, output bit acc);
    bit popOk;
    push_valid = pv;
    push_pc    = pc;
    push_instr = ins;
    pop_ready  = pr;
    flush      = fl;
    acc   = pv && (mCount != 4) && !fl;
    popOk = pr && (mCount != 0) && !fl;
    if (fl) expQ.delete();
    if (acc) expQ.push_back('{pc: pc, instr: ins});
    @(posedge clk);
    #1;
    if (fl) mCount = 0;
    else mCount = mCount + int'(acc) - int'(popOk);
    check("count", 64'(count), 64'(mCount));
  endtask

  task automatic idle();
    bit a;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    bit a;
    cycle(1'b1, pc, ins, 1'b0, 1'b0, a);
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 8 && mCount > 0; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
  endtask

  task automatic doFlush();
    bit a;
    cycle(1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b1, a);
  endtask

  initial begin
    bit a;
    int idx;
    int t;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_push_ready", 64'(push_ready), 64'(1));
    check("rst_pop_valid", 64'(pop_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_almost_full", 64'(almost_full), 64'(0));
    check("rst_flushed", 64'(flushed_cnt), 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // First push visible the following cycle
    push(32'h0, 32'h00000013);
    check("first_pop_valid", 64'(pop_valid), 64'(1));
    check("first_pop_pc", 64'(pop_pc), 64'(32'h0));
    check("first_af", 64'(almost_full), 64'(0));

    // Fill to DEPTH
    push(32'h4, 32'h00100093);
    check("af_at2", 64'(almost_full), 64'(0));
    push(32'h8, 32'h00200113);
    check("af_at3", 64'(almost_full), 64'(1));
    push(32'hC, 32'h00300193);
    check("full_push_ready", 64'(push_ready), 64'(0));
    check("full_af", 64'(almost_full), 64'(1));
    push(32'h10, 32'h00400213);
    check("full_rejects", 64'(count), 64'(4));

    // At full: pop succeeds, simultaneous push blocked
    cycle(1'b1, 32'h10, 32'h00400213, 1'b1, 1'b0, a);
    check("full_pushpop_acc", 64'(a), 64'(0));
    check("full_pushpop_cnt", 64'(count), 64'(3));
    check("full_pushpop_head", 64'(pop_pc), 64'(32'h4));

    // Simultaneous push/pop at count 2
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    cycle(1'b1, 32'h20, 32'h00500293, 1'b1, 1'b0, a);
    check("pushpop2_cnt", 64'(count), 64'(2));
    check("pushpop2_head", 64'(pop_pc), 64'(32'hC));
    drain();
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    check("empty_pop_ignored", 64'(pop_valid), 64'(0));

    // Wrap ordering: 10 entries, pop every other cycle
    idx = 0;
    t = 0;
    while (idx < 10 && t < 60) begin
      cycle(1'b1, 32'(idx * 4), 32'h1000 + 32'(idx), t[0], 1'b0, a);
      if (a) idx++;
      t++;
    end
    check("wrap_all_pushed", 64'(idx), 64'(10));
    drain();
    check("wrap_drained", 64'(expQ.size()), 64'(0));

    // Flush at count 3 with a push in the same cycle
    push(32'h100, 32'hA0);
    push(32'h104, 32'hA1);
    push(32'h108, 32'hA2);
    doFlush();
    check("flush_pop_valid", 64'(pop_valid), 64'(0));
    check("flush_cnt3", 64'(flushed_cnt), 64'(3));
    push(32'h300, 32'hB0);
    check("post_flush_head", 64'(pop_pc), 64'(32'h300));
    drain();

    // Saturation with 2-bit counter, then flushes while empty
    push(32'h400, 32'hC0);
    push(32'h404, 32'hC1);
    push(32'h408, 32'hC2);
    doFlush();
    check("sat_twice", 64'(flushed_cnt), 64'(3));
    doFlush();
    doFlush();
    check("empty_flush_cnt", 64'(flushed_cnt), 64'(3));
    check("empty_flush_ready", 64'(push_ready), 64'(1));

    // Async reset mid-burst, no clock edge
    push(32'h500, 32'hD0);
    push(32'h504, 32'hD1);
    push_valid = 1'b1;
    push_pc    = 32'h508;
    pop_ready  = 1'b1;
    reset      = 1'b0;
    #2;
    check("arst_count", 64'(count), 64'(0));
    check("arst_pop_valid", 64'(pop_valid), 64'(0));
    check("arst_push_ready", 64'(push_ready), 64'(1));
    check("arst_flushed", 64'(flushed_cnt), 64'(0));
    expQ.delete();
    mCount = 0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Accumulate then saturate: 1, 1+2=3, 3+1 stays 3
    push(32'h600, 32'hE0);
    doFlush();
    check("acc_1", 64'(flushed_cnt), 64'(1));
    push(32'h604, 32'hE1);
    push(32'h608, 32'hE2);
    doFlush();
    check("acc_3", 64'(flushed_cnt), 64'(3));
    push(32'h60C, 32'hE3);
    doFlush();
    check("acc_sat", 64'(flushed_cnt), 64'(3));

    // Pointers restart at 0 after flush: order still intact
    push(32'h700, 32'hF0);
    push(32'h704, 32'hF1);
    drain();
    idle();
    check("final_queue_empty", 64'(expQ.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
